// File: rtl/sobel_pkg.sv
// Shared types for the Sobel window generator and the kernels that consume its window.
// Window slot indices follow the p1..p9 naming: top row first, left to right.
package sobel_pkg;

  localparam int DATA_W = 8;
  localparam int WIN_N  = 9;

  typedef logic [DATA_W-1:0] pix_t;
  typedef pix_t win_t [WIN_N];

  localparam int P1 = 0;
  localparam int P2 = 1;
  localparam int P3 = 2;
  localparam int P4 = 3;
  localparam int P5 = 4;
  localparam int P6 = 5;
  localparam int P7 = 6;
  localparam int P8 = 7;
  localparam int P9 = 8;

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of storage: synchronous write, combinational read.
// A read and a write to the same address in one cycle returns the old contents.
module sobel_line_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Contents are never reset; the window generator gates output until valid lines exist.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator feeding the Sobel kernels.
// Two line buffers supply the upper rows; only fully populated windows are flagged valid.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int DATA_W = sobel_pkg::DATA_W,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_pix,
  output logic              out_valid,
  output logic              out_last,
  output logic [DATA_W-1:0] p1,
  output logic [DATA_W-1:0] p2,
  output logic [DATA_W-1:0] p3,
  output logic [DATA_W-1:0] p4,
  output logic [DATA_W-1:0] p5,
  output logic [DATA_W-1:0] p6,
  output logic [DATA_W-1:0] p7,
  output logic [DATA_W-1:0] p8,
  output logic [DATA_W-1:0] p9
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  w_col;
  logic [ROW_W-1:0]  w_row;
  logic [COL_W-1:0]  w_col_nxt;
  logic [ROW_W-1:0]  w_row_nxt;
  logic              w_win_full;
  logic              w_frame_end;
  logic [DATA_W-1:0] w_lb0_rd;
  logic [DATA_W-1:0] w_lb1_rd;
  logic [DATA_W-1:0] r_win [WIN_N];
  logic              r_valid;
  logic              r_last;

  // A start-of-frame pixel is treated as (0,0) regardless of where the counters were.
  always_comb begin
    w_col       = in_sof ? '0 : r_col;
    w_row       = in_sof ? '0 : r_row;
    w_win_full  = (w_row >= ROW_TWO) && (w_col >= COL_TWO);
    w_frame_end = (w_row == ROW_LAST) && (w_col == COL_LAST) && (w_row >= ROW_TWO);
    w_col_nxt   = w_col + 1'b1;
    w_row_nxt   = w_row;
    if (w_col == COL_LAST) begin
      w_col_nxt = '0;
      w_row_nxt = (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (in_valid) begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_valid <= in_valid && w_win_full;
      r_last  <= in_valid && w_frame_end;
    end
  end

  // Each accepted pixel shifts the window left and brings in the column {line r-2, line r-1, new}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN_N; i++) begin
        r_win[i] <= '0;
      end
    end else if (in_valid) begin
      r_win[P1] <= r_win[P2];
      r_win[P2] <= r_win[P3];
      r_win[P3] <= w_lb1_rd;
      r_win[P4] <= r_win[P5];
      r_win[P5] <= r_win[P6];
      r_win[P6] <= w_lb0_rd;
      r_win[P7] <= r_win[P8];
      r_win[P8] <= r_win[P9];
      r_win[P9] <= in_pix;
    end
  end

  sobel_line_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W),
    .ADDR_W (COL_W)
  ) u_lb0 (
    .clk     (clk),
    .i_we    (in_valid),
    .i_addr  (w_col),
    .i_wdata (in_pix),
    .o_rdata (w_lb0_rd)
  );

  sobel_line_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W),
    .ADDR_W (COL_W)
  ) u_lb1 (
    .clk     (clk),
    .i_we    (in_valid),
    .i_addr  (w_col),
    .i_wdata (w_lb0_rd),
    .o_rdata (w_lb1_rd)
  );

  assign out_valid = r_valid;
  assign out_last  = r_last;
  assign p1 = r_win[P1];
  assign p2 = r_win[P2];
  assign p3 = r_win[P3];
  assign p4 = r_win[P4];
  assign p5 = r_win[P5];
  assign p6 = r_win[P6];
  assign p7 = r_win[P7];
  assign p8 = r_win[P8];
  assign p9 = r_win[P9];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench for sobel_window_gen on a 5x4 frame.
// Directed table for the first frame plus a frame-image scoreboard for gaps, resets and resyncs.
module tb_sobel_window_gen;

  localparam int W = 5;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rstN;
  logic       inValid;
  logic       inSof;
  logic [7:0] inPix;
  logic       outValid;
  logic       outLast;
  logic [7:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;

  always #5 clk = ~clk;

  sobel_window_gen #(
    .DATA_W (8),
    .IMG_W  (W),
    .IMG_H  (H)
  ) dut (
    .clk       (clk),
    .rst_n     (rstN),
    .in_valid  (inValid),
    .in_sof    (inSof),
    .in_pix    (inPix),
    .out_valid (outValid),
    .out_last  (outLast),
    .p1 (p1), .p2 (p2), .p3 (p3),
    .p4 (p4), .p5 (p5), .p6 (p6),
    .p7 (p7), .p8 (p8), .p9 (p9)
  );

  typedef struct packed {
    logic            last;
    logic [8:0][7:0] win;
  } exp_t;

  typedef struct {
    int         r;
    int         c;
    logic       expValid;
    logic       expLast;
    logic [7:0] e1, e3, e5, e7, e9;
  } vec_t;

  exp_t       expQ[$];
  vec_t       vecs[W*H];
  logic [7:0] img[H][W];
  int         modelRow = 0;
  int         modelCol = 0;
  int         checks   = 0;
  int         errors   = 0;
  int         winCount = 0;
  logic       lastSeenValid = 1'b0;

  task automatic check(input string name, input logic [71:0] actual, input logic [71:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // The model keeps the frame as an image and builds windows from it directly.
  task automatic applyStimulus(input logic v, input logic s, input logic [7:0] pix);
    int   r, c;
    exp_t e;
    inValid = v;
    inSof   = s;
    inPix   = pix;
    if (v) begin
      r = s ? 0 : modelRow;
      c = s ? 0 : modelCol;
      img[r][c] = pix;
      if (r >= 2 && c >= 2) begin
        e.last = (r == H-1) && (c == W-1);
        for (int k = 0; k < 3; k++) begin
          e.win[k]   = img[r-2][c-2+k];
          e.win[3+k] = img[r-1][c-2+k];
          e.win[6+k] = img[r][c-2+k];
        end
        expQ.push_back(e);
      end
      if (c == W-1) begin
        modelCol = 0;
        modelRow = (r == H-1) ? 0 : r + 1;
      end else begin
        modelCol = c + 1;
        modelRow = r;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    exp_t            e;
    logic [8:0][7:0] act;
    if (!rstN) begin
      lastSeenValid = 1'b0;
    end else begin
      if (outValid) begin
        winCount++;
        check("validAfterIdle", {71'd0, lastSeenValid}, 72'd1);
        act = {p9, p8, p7, p6, p5, p4, p3, p2, p1};
        if (expQ.size() == 0) begin
          check("unexpectedWindow", {71'd0, outValid}, 72'd0);
        end else begin
          e = expQ.pop_front();
          check("window", {0, act}, {0, e.win});
          check("last", {71'd0, outLast}, {71'd0, e.last});
        end
      end else begin
        check("lastWithoutValid", {71'd0, outLast}, 72'd0);
      end
      lastSeenValid = inValid;
    end
  endtask

  always @(negedge clk) checkOutput();

  task automatic driveFrame(input logic [7:0] base, input int nPix, input int gapMode);
    for (int i = 0; i < nPix; i++) begin
      applyStimulus(1'b1, i == 0, base + 8'(16*(i/W) + (i%W)));
      if (gapMode == 1) begin
        if (i % 2 == 1) applyStimulus(1'b0, 1'b0, 8'h00);
        else begin
          for (int g = 0; g < int'($urandom_range(0, 2)); g++) applyStimulus(1'b0, 1'b0, 8'h00);
        end
      end
    end
  endtask

  task automatic drain(input string name, input int expWindows);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00);
    check({name, "_queueEmpty"}, 72'(expQ.size()), 72'd0);
    check({name, "_windowCount"}, 72'(winCount), 72'(expWindows));
    winCount = 0;
  endtask

  task automatic checkAllZero(input string name);
    check({name, "_valid"}, {71'd0, outValid}, 72'd0);
    check({name, "_last"}, {71'd0, outLast}, 72'd0);
    check({name, "_pix"}, {0, p9, p8, p7, p6, p5, p4, p3, p2, p1}, 72'd0);
  endtask

  initial begin
    rstN    = 1'b0;
    inValid = 1'b0;
    inSof   = 1'b0;
    inPix   = 8'h00;

    for (int i = 0; i < W*H; i++) begin
      vecs[i].r = i / W;
      vecs[i].c = i % W;
      vecs[i].expValid = 1'b0;
      vecs[i].expLast  = 1'b0;
      vecs[i].e1 = 8'h00; vecs[i].e3 = 8'h00; vecs[i].e5 = 8'h00;
      vecs[i].e7 = 8'h00; vecs[i].e9 = 8'h00;
    end
    vecs[12] = '{2, 2, 1'b1, 1'b0, 8'h00, 8'h02, 8'h11, 8'h20, 8'h22};
    vecs[13] = '{2, 3, 1'b1, 1'b0, 8'h01, 8'h03, 8'h12, 8'h21, 8'h23};
    vecs[14] = '{2, 4, 1'b1, 1'b0, 8'h02, 8'h04, 8'h13, 8'h22, 8'h24};
    vecs[17] = '{3, 2, 1'b1, 1'b0, 8'h10, 8'h12, 8'h21, 8'h30, 8'h32};
    vecs[18] = '{3, 3, 1'b1, 1'b0, 8'h11, 8'h13, 8'h22, 8'h31, 8'h33};
    vecs[19] = '{3, 4, 1'b1, 1'b1, 8'h12, 8'h14, 8'h23, 8'h32, 8'h34};

    #3;
    checkAllZero("reset");
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;

    $display("[TB] frame with continuous valid");
    for (int i = 0; i < W*H; i++) begin
      applyStimulus(1'b1, i == 0, 8'(16*vecs[i].r + vecs[i].c));
      check("t1_valid", {71'd0, outValid}, {71'd0, vecs[i].expValid});
      check("t1_last", {71'd0, outLast}, {71'd0, vecs[i].expLast});
      if (vecs[i].expValid) begin
        check("t1_p1", 72'(p1), 72'(vecs[i].e1));
        check("t1_p3", 72'(p3), 72'(vecs[i].e3));
        check("t1_p5", 72'(p5), 72'(vecs[i].e5));
        check("t1_p7", 72'(p7), 72'(vecs[i].e7));
        check("t1_p9", 72'(p9), 72'(vecs[i].e9));
      end
    end
    drain("t1", 6);

    $display("[TB] frame with gapped valid");
    driveFrame(8'h00, W*H, 1);
    drain("t2", 6);

    $display("[TB] back-to-back frames");
    driveFrame(8'h00, W*H, 0);
    for (int i = 0; i < W*H; i++) begin
      applyStimulus(1'b1, i == 0, 8'h80 + 8'(16*(i/W) + (i%W)));
      if (i == 12) begin
        check("t3_firstP1", 72'(p1), 72'h80);
        check("t3_firstP9", 72'(p9), 72'hA2);
      end
    end
    drain("t3", 12);

    $display("[TB] asynchronous reset mid-row");
    driveFrame(8'h00, 14, 0);
    check("t4_preResetValid", {71'd0, outValid}, 72'd1);
    #2;
    rstN = 1'b0;
    #1;
    checkAllZero("t4_async");
    expQ.delete();
    winCount = 0;
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    rstN = 1'b1;
    driveFrame(8'h00, W*H, 0);
    drain("t4", 6);

    $display("[TB] start-of-frame resync mid-frame");
    driveFrame(8'h00, 16, 0);
    driveFrame(8'h40, W*H, 0);
    drain("t5", 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
